// File: rtl/axi4_traffic_master.sv
// axi4_traffic_master
//
// AXI4 master self-test engine. Writes num_bursts INCR bursts of a
// deterministic pattern starting at base_addr, optionally reads the same
// region back and checks it, and counts response, data and RLAST errors.
// Exactly one transaction is outstanding at any time.
//
// Pattern for global word k (k = burst*BURST_LEN + beat) is (seed + k)
// replicated across the data bus.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   start                 one-cycle start request (sampled in IDLE only)
//   mode                  0 write, 1 read, 2/3 write then read-verify
//   base_addr             first burst address (burst-size aligned)
//   num_bursts            bursts per phase
//   seed                  pattern seed
//   busy, done            run status, one-cycle completion pulse
//   resp_err, data_err    saturating error counters
//   last_err              sticky RLAST placement error
//   M_AXI_*               AXI4 master channels AW, W, B, AR, R
//
// state | meaning
// IDLE  | waiting for start
// WA    | write address valid
// WD    | write data beats
// WB    | waiting for write response
// RA    | read address valid
// RD    | accepting and checking read beats
// FIN   | one-cycle done pulse

module axi4_traffic_master #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int BURST_LEN          = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    input  logic [1:0]                        mode,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_WIDTH-1:0]              num_bursts,
    input  logic [31:0]                       seed,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_WIDTH-1:0]              resp_err,
    output logic [CNT_WIDTH-1:0]              data_err,
    output logic                              last_err,

    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WA   = 3'd1;
    localparam logic [2:0] S_WD   = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_RA   = 3'd4;
    localparam logic [2:0] S_RD   = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int DW          = C_M_AXI_DATA_WIDTH;
    localparam int BEAT_BYTES  = DW / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;

    localparam logic [8:0]           LAST_BEAT = 9'(BURST_LEN - 1);
    localparam logic [AW-1:0]        ADDR_STEP = AW'(BURST_BYTES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [7:0]           AXI_LEN   = 8'(BURST_LEN - 1);
    localparam logic [2:0]           AXI_SIZE  = 3'($clog2(BEAT_BYTES));
    localparam logic [1:0]           AXI_INCR  = 2'b01;
    localparam logic [1:0]           MODE_RD   = 2'd1;
    localparam logic [1:0]           MODE_WR   = 2'd0;

    logic [2:0]           r_state;
    logic [1:0]           r_mode;
    logic [AW-1:0]        r_base;
    logic [AW-1:0]        r_addr;
    logic [CNT_WIDTH-1:0] r_num;
    logic [CNT_WIDTH-1:0] r_burst;
    logic [CNT_WIDTH-1:0] r_resp_err;
    logic [CNT_WIDTH-1:0] r_data_err;
    logic [31:0]          r_seed;
    logic [31:0]          r_word;
    logic [8:0]           r_beat;
    logic                 r_last_err;

    logic [31:0]          w_word_pat;
    logic [DW-1:0]        w_pattern;
    logic                 w_last_beat;
    logic                 w_last_burst;
    logic                 w_b_hs;
    logic                 w_r_hs;
    logic                 w_resp_inc;
    logic                 w_data_inc;
    logic                 w_unused;

    assign w_word_pat   = r_seed + r_word;
    assign w_pattern    = {(DW/32){w_word_pat}};
    assign w_last_beat  = (r_beat == LAST_BEAT);
    // r_num is never zero outside IDLE/FIN: a zero count goes straight to FIN.
    assign w_last_burst = (r_burst == (r_num - CNT_ONE));
    assign w_b_hs       = (r_state == S_WB) && M_AXI_BVALID;
    assign w_r_hs       = (r_state == S_RD) && M_AXI_RVALID;
    assign w_resp_inc   = (w_b_hs && (M_AXI_BRESP != 2'b00)) ||
                          (w_r_hs && (M_AXI_RRESP != 2'b00));
    // Read-only runs have no pattern written beforehand, so data is not checked.
    assign w_data_inc   = w_r_hs && (r_mode != MODE_RD) && (M_AXI_RDATA != w_pattern);
    assign w_unused     = ^{M_AXI_BID, M_AXI_RID};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'd0;
            r_base     <= '0;
            r_addr     <= '0;
            r_num      <= '0;
            r_burst    <= '0;
            r_resp_err <= '0;
            r_data_err <= '0;
            r_seed     <= 32'd0;
            r_word     <= 32'd0;
            r_beat     <= 9'd0;
            r_last_err <= 1'b0;
        end else begin
            if (w_resp_inc && (r_resp_err != CNT_MAX)) begin
                r_resp_err <= r_resp_err + CNT_ONE;
            end
            if (w_data_inc && (r_data_err != CNT_MAX)) begin
                r_data_err <= r_data_err + CNT_ONE;
            end
            if (w_r_hs && (M_AXI_RLAST != w_last_beat)) begin
                r_last_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_base     <= base_addr;
                        r_addr     <= base_addr;
                        r_num      <= num_bursts;
                        r_seed     <= seed;
                        r_burst    <= '0;
                        r_beat     <= 9'd0;
                        r_word     <= 32'd0;
                        r_resp_err <= '0;
                        r_data_err <= '0;
                        r_last_err <= 1'b0;
                        if (num_bursts == '0) begin
                            r_state <= S_FIN;
                        end else if (mode == MODE_RD) begin
                            r_state <= S_RA;
                        end else begin
                            r_state <= S_WA;
                        end
                    end
                end
                S_WA: begin
                    if (M_AXI_AWREADY) begin
                        r_state <= S_WD;
                    end
                end
                S_WD: begin
                    if (M_AXI_WREADY) begin
                        r_word <= r_word + 32'd1;
                        if (w_last_beat) begin
                            r_beat  <= 9'd0;
                            r_state <= S_WB;
                        end else begin
                            r_beat <= r_beat + 9'd1;
                        end
                    end
                end
                S_WB: begin
                    if (M_AXI_BVALID) begin
                        if (!w_last_burst) begin
                            r_burst <= r_burst + CNT_ONE;
                            r_addr  <= r_addr + ADDR_STEP;
                            r_state <= S_WA;
                        end else if (r_mode == MODE_WR) begin
                            r_state <= S_FIN;
                        end else begin
                            // Read-verify replays the same region and word sequence.
                            r_burst <= '0;
                            r_addr  <= r_base;
                            r_word  <= 32'd0;
                            r_state <= S_RA;
                        end
                    end
                end
                S_RA: begin
                    if (M_AXI_ARREADY) begin
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (M_AXI_RVALID) begin
                        r_word <= r_word + 32'd1;
                        // Burst length is counted locally; RLAST only feeds last_err.
                        if (w_last_beat) begin
                            r_beat <= 9'd0;
                            if (!w_last_burst) begin
                                r_burst <= r_burst + CNT_ONE;
                                r_addr  <= r_addr + ADDR_STEP;
                                r_state <= S_RA;
                            end else begin
                                r_state <= S_FIN;
                            end
                        end else begin
                            r_beat <= r_beat + 9'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done     = (r_state == S_FIN);
    assign resp_err = r_resp_err;
    assign data_err = r_data_err;
    assign last_err = r_last_err;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = AXI_LEN;
    assign M_AXI_AWSIZE  = AXI_SIZE;
    assign M_AXI_AWBURST = AXI_INCR;
    assign M_AXI_AWVALID = (r_state == S_WA);

    assign M_AXI_WDATA   = (r_state == S_WD) ? w_pattern : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_state == S_WD) && w_last_beat;
    assign M_AXI_WVALID  = (r_state == S_WD);

    assign M_AXI_BREADY  = (r_state == S_WB);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARLEN   = AXI_LEN;
    assign M_AXI_ARSIZE  = AXI_SIZE;
    assign M_AXI_ARBURST = AXI_INCR;
    assign M_AXI_ARVALID = (r_state == S_RA);

    assign M_AXI_RREADY  = (r_state == S_RD);

endmodule
